// File: rtl/hilo_mult_seq_pkg.sv
// Shared CPU definitions for the HI/LO multiplier sequencer and the decoder.
// Holds the FSM state type, the operand width and the regsel codes for HI/LO.
package hilo_mult_seq_pkg;

  localparam int MULT_WIDTH = 32;

  localparam logic [1:0] REGSEL_HI = 2'd1;
  localparam logic [1:0] REGSEL_LO = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/hilo_mult_seq.sv
// Iterative shift-add mult/multu unit that owns HI/LO and stalls EX.
// Ports: clk, rst (sync, active-high), start, is_signed, a, b, hilo_read
//        in; busy, done, stall, hi, lo out.
module hilo_mult_seq
  import hilo_mult_seq_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_read,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    state_d  = state_q;
    mag_a    = a;
    mag_b    = b;
    sum      = '0;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    prod     = '0;
    prod_fix = '0;
    stall    = busy_q & (hilo_read | start);

    // |-2^(W-1)| wraps to 2^(W-1), which is exact as an unsigned value.
    if (is_signed) begin
      if (a[WIDTH-1]) mag_a = ~a + 1'b1;
      if (b[WIDTH-1]) mag_b = ~b + 1'b1;
    end

    // acc[W] is always zero here (cleared on start, shifted in as 0).
    sum = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_d    = {1'b0, sum[WIDTH:1]};
    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};

    prod     = {acc_q[WIDTH-1:0], mplier_q};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;

    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (cnt_q == CNT_LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) done_q <= 1'b1;
        end
        DONE: begin
          hi_q   <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q   <= prod_fix[WIDTH-1:0];
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Directed self-checking bench for hilo_mult_seq.
// Cycle N means the interval after edge N-1, sampled #1 after that edge.
module tb_hilo_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        hilo_read;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;
  logic saw_done;
  logic stall_ok;

  hilo_mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hilo_read (hilo_read),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_mult(input string tag, input logic sgn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    tick();
    start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    chk({tag, "_busy1"}, {63'd0, busy}, 64'd1);
    repeat (31) tick();
    chk({tag, "_done32"}, {63'd0, done}, 64'd0);
    tick();
    chk({tag, "_done33"}, {63'd0, done}, 64'd1);
    tick();
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    chk({tag, "_busy34"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0;
    a = '0; b = '0; hilo_read = 1'b0;
    tick(); tick();
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hi",    {32'd0, hi},    64'd0);
    chk("rst_lo",    {32'd0, lo},    64'd0);
    rst = 1'b0;
    tick();

    run_mult("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001);
    run_mult("sneg", 1'b1, 32'hFFFF_FFFD, 32'd5,
             32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_mult("uneg", 1'b0, 32'hFFFF_FFFD, 32'd5,
             32'h0000_0004, 32'hFFFF_FFF1);
    run_mult("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0000_0000);
    run_mult("smin1", 1'b1, 32'h8000_0000, 32'd1,
             32'hFFFF_FFFF, 32'h8000_0000);

    // Read interlock: mfhi/mflo waits in EX for the whole multiply.
    start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd6;
    tick();
    start = 1'b0; hilo_read = 1'b1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (c < 33) tick();
    end
    chk("rd_stall_1_33", {63'd0, stall_ok}, 64'd1);
    chk("rd_done33", {63'd0, done}, 64'd1);
    tick();
    chk("rd_stall34", {63'd0, stall}, 64'd0);
    chk("rd_hi34", {32'd0, hi}, 64'd0);
    chk("rd_lo34", {32'd0, lo}, 64'd42);
    hilo_read = 1'b0;
    tick();

    // Back-to-back: second mult held in EX until the first finishes.
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000;
    #0;
    chk("b2b_stall5", {63'd0, stall}, 64'd1);
    repeat (28) tick();
    chk("b2b_done33", {63'd0, done}, 64'd1);
    chk("b2b_stall33", {63'd0, stall}, 64'd1);
    tick();
    chk("b2b_hi34", {32'd0, hi}, 64'd0);
    chk("b2b_lo34", {32'd0, lo}, 64'd12);
    chk("b2b_stall34", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0;
    chk("b2b_busy35", {63'd0, busy}, 64'd1);
    repeat (32) tick();
    chk("b2b_done67", {63'd0, done}, 64'd1);
    tick();
    chk("b2b_hi68", {32'd0, hi}, 64'd1);
    chk("b2b_lo68", {32'd0, lo}, 64'd0);

    // Reset mid-operation discards the partial product.
    start = 1'b1; is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'd2;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy11", {63'd0, busy}, 64'd0);
    chk("mrst_hi11", {32'd0, hi}, 64'd0);
    chk("mrst_lo11", {32'd0, lo}, 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("mrst_no_done", {63'd0, saw_done}, 64'd0);
    chk("mrst_hi_idle", {32'd0, hi}, 64'd0);
    run_mult("post_rst", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'h0000_0000, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hilo_mult_seq.md
# hilo_mult_seq

Iterative shift-add multiplier sequencer for `mult`/`multu`. It owns the architectural HI/LO registers, runs one 32-iteration multiply per request, and raises a pipeline stall when a later instruction needs HI/LO or the unit before the product is ready. It sits beside the EX-stage ALU and is started by the decoder's `enhilo_EX` indication. Its `stall` output feeds the fetch/decode stall logic.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  EX holds a `mult` or `multu` this cycle (the decoder's `enhilo_EX`).
- `is_signed`  in  1  1 = `mult`, 0 = `multu`; sampled with `start`.
- `a`, `b`  in  `WIDTH`  rs and rt operands; sampled with `start`.
- `hilo_read`  in  1  EX holds `mfhi` or `mflo` (regsel_EX is 1 or 2).
- `busy`  out  1  a multiply is in flight.
- `done`  out  1  single-cycle pulse in the cycle HI/LO are written.
- `stall`  out  1  the pipeline must hold the EX instruction this cycle.
- `hi`, `lo`  out  `WIDTH`  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE.** When `start` is high:
  - latch `mcand = |a|` and `mplier = |b|` when `is_signed`, otherwise the raw values;
  - latch `neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1])`;
  - clear `acc` (`WIDTH+1` bits), clear `cnt`, and go to CALC.
- **Magnitudes.** `|x|` is a `WIDTH`-bit unsigned two's-complement negate. The magnitude of `-2^(WIDTH-1)` is `2^(WIDTH-1)`, which fits with no overflow.
- **CALC, per cycle.**
  - If `mplier[0]`, add `mcand` to `acc[WIDTH-1:0]`; the carry goes into `acc[WIDTH]`.
  - Then shift `{acc, mplier}` right by 1.
  - `cnt` increments.
  - When `cnt == WIDTH-1`, go to DONE next.
- **DONE.**
  - Form `prod = {acc[WIDTH-1:0], mplier}` (`2*WIDTH` bits).
  - If `neg`, take the two's complement of `prod`.
  - Write `hi <= prod[2W-1:W]` and `lo <= prod[W-1:0]`.
  - Pulse `done` and return to IDLE.
- `busy` is high in CALC and DONE.
- `stall = busy & (hilo_read | start)`. The held `mfhi`/`mflo`/`mult` re-presents after the stall and is accepted in IDLE.
- `start` while `busy` is ignored by the FSM; the stall keeps the instruction in EX.
- `start` and `hilo_read` are never both high (one EX instruction).
- Operand registers change only on an accepted `start`.
- HI/LO change only in DONE or on reset.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `done`, `stall` = 0;
  - `hi`, `lo`, `acc`, `mplier`, `mcand`, `cnt`, `neg` = 0.
- Reset mid-operation: the next cycle is IDLE, HI/LO = 0, and the partial product is discarded.
- Latency:
  - `start` sampled at edge 0;
  - CALC occupies cycles 1..WIDTH;
  - DONE is cycle WIDTH+1, with `done` high that cycle;
  - new HI/LO are visible from cycle WIDTH+2 (34 for WIDTH=32).
- Throughput: one multiply per WIDTH+2 cycles. A back-to-back `start` is accepted the cycle after DONE.
- `hilo_read` in the DONE cycle: stall is high. The next cycle (IDLE) reads the new HI/LO.
- `stall` is combinational from state and inputs, with no register delay.
- `hi` and `lo` are registered outputs.

## Structure
- Shared CPU package:
  - `mult_state_t` enum (IDLE, CALC, DONE);
  - the `MULT_WIDTH = 32` constant;
  - the `REGSEL_HI = 2'd1` and `REGSEL_LO = 2'd2` constants, reused by the decoder.
- Single module, no sub-modules.
- One `always_ff` holds state, counter and datapath registers; one `always_comb` holds next-state, stall and sign fixup.
- `cnt` is `$clog2(WIDTH)` bits.

## Test plan
- **Unsigned max.** `multu` with `a = b = 0xFFFFFFFF` → `done` at cycle 33; `hi = 0xFFFFFFFE`, `lo = 0x00000001` at cycle 34.
- **Signed negative.** `mult` with `a = 0xFFFFFFFD` (-3), `b = 5` → `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFF1`. The same operands as `multu` → `hi = 0x00000004`, `lo = 0xFFFFFFF1`.
- **Most-negative operands.** `mult` with `a = b = 0x80000000` → `hi = 0x40000000`, `lo = 0x00000000`. `mult` with `a = 0x80000000`, `b = 1` → `hi = 0xFFFFFFFF`, `lo = 0x80000000`.
- **Read interlock.** `hilo_read` high from cycle 1 onward → `stall = 1` in cycles 1..33, `stall = 0` in cycle 34 with the new value on `hi`.
- **Back-to-back multiply.** A second `start` at cycle 5 → `stall = 1` and operands unchanged. Only the first product is written at cycle 33. The second is accepted at cycle 34 and completes at cycle 67.
- **Reset mid-operation.** `rst` at cycle 10 → cycle 11 has `busy = 0`, `hi = lo = 0`, `done` never pulses. A fresh `start` then completes normally.
